// File: rtl/branch_pc_ctrl_if.sv
// rtl/branch_pc_ctrl_if.sv - EX-stage operand bus and shared branch adder port for branch_pc_ctrl
interface branch_pc_ctrl_if;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic [31:0] adder_pc;
  logic [31:0] adder_imm;
  logic [31:0] adder_target;

  // EX stage and adder side: drives operands and the adder sum
  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
    output ex_pc, ex_rs1, ex_rs2, ex_imm, adder_target,
    input  adder_pc, adder_imm
  );

  // Next-PC controller side
  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
    input  ex_pc, ex_rs1, ex_rs2, ex_imm, adder_target,
    output adder_pc, adder_imm
  );
endinterface

// File: rtl/branch_pc_ctrl.sv
// rtl/branch_pc_ctrl.sv - next-PC controller with branch resolution, flush and misalign halt (optional stats: BRANCH_PC_CTRL_STATS_EN)
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  branch_pc_ctrl_if.slave       ex,
  output logic [31:0]           pc_out,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  redirect_q,
  output logic                  halted,
  output logic [31:0]           br_total_cnt,
  output logic [31:0]           br_taken_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic        redirect_next;
  logic        flush;
  logic        cond;
  logic        is_jalr, is_jal, is_br;
  logic        take, misalign;
  logic [31:0] tgt;

  // Flag precedence: jalr over jal over branch
  assign is_jalr = ex.ex_is_jalr;
  assign is_jal  = ex.ex_is_jal & ~ex.ex_is_jalr;
  assign is_br   = ex.ex_is_branch & ~ex.ex_is_jal & ~ex.ex_is_jalr;

  // JALR bases off rs1, everything else off the instruction PC
  always_comb begin
    ex.adder_pc  = is_jalr ? ex.ex_rs1 : ex.ex_pc;
    ex.adder_imm = ex.ex_imm;
  end

  // Branch condition; 010/011 are not real conditions and never take
  always_comb begin
    cond = 1'b0;
    case (ex.ex_funct3)
      3'b000:  cond = (ex.ex_rs1 == ex.ex_rs2);
      3'b001:  cond = (ex.ex_rs1 != ex.ex_rs2);
      3'b100:  cond = ($signed(ex.ex_rs1) <  $signed(ex.ex_rs2));
      3'b101:  cond = ($signed(ex.ex_rs1) >= $signed(ex.ex_rs2));
      3'b110:  cond = (ex.ex_rs1 <  ex.ex_rs2);
      3'b111:  cond = (ex.ex_rs1 >= ex.ex_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign tgt      = {ex.adder_target[31:1], ex.adder_target[0] & ~is_jalr};
  assign take     = ex.ex_valid & ~stall & (is_jalr | is_jal | (is_br & cond));
  assign misalign = take & tgt[1];

  // Next state, next PC and Mealy flush; HALT ignores every input
  always_comb begin
    state_next    = state;
    pc_next       = pc_q;
    redirect_next = 1'b0;
    flush         = 1'b0;
    case (state)
      RUN: begin
        flush = take;
        if (take && !misalign) begin
          pc_next       = tgt;
          redirect_next = 1'b1;
        end else if (take && misalign) begin
          state_next = HALT;
        end else if (!stall) begin
          pc_next = pc_q + 32'd4;
        end
      end
      HALT: begin
        flush = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // State, PC and redirect flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      redirect_q <= redirect_next;
    end
  end

  assign pc_out   = pc_q;
  assign flush_if = flush;
  assign flush_id = flush;
  assign halted   = (state == HALT);

`ifdef BRANCH_PC_CTRL_STATS_EN
  logic [31:0] total_q, taken_q;
  logic        br_event;

  assign br_event = (state == RUN) & ex.ex_valid & is_br & ~stall;

  // Resolved and taken branch counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= 32'h0;
      taken_q <= 32'h0;
    end else if (br_event) begin
      total_q <= total_q + 32'd1;
      if (cond) taken_q <= taken_q + 32'd1;
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
`else
  assign br_total_cnt = 32'h0;
  assign br_taken_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb/tb_branch_pc_ctrl.sv - directed self-checking bench for branch_pc_ctrl
module tb_branch_pc_ctrl;
  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pc_out;
  logic        flush_if, flush_id, redirect_q, halted;
  logic [31:0] br_total_cnt, br_taken_cnt;
  int          checks;
  int          errors;

  branch_pc_ctrl_if bus ();

  // Behavioural model of the shared branch adder
  assign bus.adder_target = bus.adder_pc + bus.adder_imm;

  branch_pc_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex           (bus.slave),
    .pc_out       (pc_out),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .redirect_q   (redirect_q),
    .halted       (halted),
    .br_total_cnt (br_total_cnt),
    .br_taken_cnt (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jal    = 1'b0;
    bus.ex_is_jalr   = 1'b0;
    bus.ex_funct3    = 3'b000;
    bus.ex_pc        = 32'h0;
    bus.ex_rs1       = 32'h0;
    bus.ex_rs2       = 32'h0;
    bus.ex_imm       = 32'h0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2);
    idle();
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = 1'b1;
    bus.ex_funct3    = f3;
    bus.ex_pc        = pc;
    bus.ex_imm       = imm;
    bus.ex_rs1       = rs1;
    bus.ex_rs2       = rs2;
  endtask

  task automatic set_jalr(input logic [31:0] rs1, input logic [31:0] imm);
    idle();
    bus.ex_valid   = 1'b1;
    bus.ex_is_jalr = 1'b1;
    bus.ex_pc      = 32'h0000_0500;
    bus.ex_rs1     = rs1;
    bus.ex_imm     = imm;
  endtask

  task automatic set_jal(input logic [31:0] pc, input logic [31:0] imm);
    idle();
    bus.ex_valid  = 1'b1;
    bus.ex_is_jal = 1'b1;
    bus.ex_pc     = pc;
    bus.ex_imm    = imm;
  endtask

  initial begin
    logic [31:0] exp_total, exp_taken;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    stall  = 1'b0;
    idle();

    // Reset state
    repeat (2) cyc();
    check("rst_pc", pc_out, 32'h100);
    check("rst_redirect", {31'h0, redirect_q}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_total", br_total_cnt, 32'h0);
    check("rst_taken", br_taken_cnt, 32'h0);
    rst = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      #2;
      check("seq_flush_if", {31'h0, flush_if}, 32'h0);
      check("seq_flush_id", {31'h0, flush_id}, 32'h0);
      cyc();
      check("seq_pc", pc_out, 32'h100 + 32'(4 * i));
    end

    // BEQ taken
    set_br(3'b000, 32'h200, 32'h40, 32'd5, 32'd5);
    #2;
    check("beq_adder_pc", bus.adder_pc, 32'h200);
    check("beq_adder_imm", bus.adder_imm, 32'h40);
    check("beq_flush_if", {31'h0, flush_if}, 32'h1);
    check("beq_flush_id", {31'h0, flush_id}, 32'h1);
    cyc();
    check("beq_pc", pc_out, 32'h240);
    check("beq_redirect", {31'h0, redirect_q}, 32'h1);
    idle();
    cyc();
    check("after_beq_pc", pc_out, 32'h244);
    check("after_beq_redirect", {31'h0, redirect_q}, 32'h0);

    // BLT signed taken, BLTU unsigned not taken
    set_br(3'b100, 32'h300, 32'h20, 32'hFFFF_FFFF, 32'd1);
    #2;
    check("blt_flush", {31'h0, flush_if}, 32'h1);
    cyc();
    check("blt_pc", pc_out, 32'h320);
    set_br(3'b110, 32'h300, 32'h20, 32'hFFFF_FFFF, 32'd1);
    #2;
    check("bltu_flush", {31'h0, flush_if}, 32'h0);
    cyc();
    check("bltu_pc", pc_out, 32'h324);
    check("bltu_redirect", {31'h0, redirect_q}, 32'h0);

    // JALR clears bit 0 of the target
    set_jalr(32'h1001, 32'h0);
    #2;
    check("jalr_adder_pc", bus.adder_pc, 32'h1001);
    cyc();
    check("jalr_pc", pc_out, 32'h1000);
    check("jalr_redirect", {31'h0, redirect_q}, 32'h1);

    // Misaligned JALR halts the core
    set_jalr(32'h1002, 32'h0);
    #2;
    check("mis_flush", {31'h0, flush_if}, 32'h1);
    cyc();
    check("mis_halted", {31'h0, halted}, 32'h1);
    check("mis_pc", pc_out, 32'h1000);
    check("mis_redirect", {31'h0, redirect_q}, 32'h0);
    set_jal(32'h800, 32'h40);
    #2;
    check("halt_flush_if", {31'h0, flush_if}, 32'h1);
    check("halt_flush_id", {31'h0, flush_id}, 32'h1);
    cyc();
    check("halt_pc_frozen", pc_out, 32'h1000);
    check("halt_still", {31'h0, halted}, 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    check("halt_rst_pc", pc_out, 32'h100);
    check("halt_rst_halted", {31'h0, halted}, 32'h0);

    // Taken BNE held off by stall
    stall = 1'b1;
    set_br(3'b001, 32'h600, 32'h10, 32'd1, 32'd2);
    for (int i = 0; i < 2; i++) begin
      #2;
      check("stall_flush", {31'h0, flush_if}, 32'h0);
      cyc();
      check("stall_pc", pc_out, 32'h100);
    end
    stall = 1'b0;
    #2;
    check("unstall_flush", {31'h0, flush_id}, 32'h1);
    cyc();
    check("unstall_pc", pc_out, 32'h610);
    check("unstall_redirect", {31'h0, redirect_q}, 32'h1);

    // PC wrap at the top of the address space
    set_jal(32'hFFFF_FFF0, 32'h0000_000C);
    cyc();
    check("wrap_jal_pc", pc_out, 32'hFFFF_FFFC);
    idle();
    cyc();
    check("wrap_pc", pc_out, 32'h0);

    // Branch statistics: 4 branches, 3 taken, plus one JAL
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_br(3'b000, 32'h200, 32'h40, 32'd5, 32'd5);
    cyc();
    set_br(3'b101, 32'h200, 32'h40, 32'd1, 32'd2);
    cyc();
    set_br(3'b111, 32'h300, 32'h20, 32'hFFFF_FFFF, 32'd1);
    cyc();
    set_br(3'b001, 32'h600, 32'h10, 32'd1, 32'd2);
    cyc();
    set_jal(32'h0, 32'h8);
    cyc();
    idle();
    cyc();
`ifdef BRANCH_PC_CTRL_STATS_EN
    exp_total = 32'd4;
    exp_taken = 32'd3;
`else
    exp_total = 32'd0;
    exp_taken = 32'd0;
`endif
    check("stats_total", br_total_cnt, exp_total);
    check("stats_taken", br_taken_cnt, exp_taken);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
